neo_spike_detector: RTL and testbench

- Reader-side companion to the NEO energy stage: scans the energy buffer the NEO block writes (signed N-bit words at addresses 0..M-1) and emits one event per detected spike.
- Spike = energy word strictly greater than a threshold, with a refractory window suppressing the following REFRACT addresses.
- Events leave over a valid/ready handshake to the downstream spike logger. Per-scan spike count and a done pulse go to the controller.

---
 rtl/neo_pkg.sv | 27 ++
 rtl/neo_refractory_ctr.sv | 48 ++++
 rtl/neo_spike_detector.sv | 180 ++++++++++++++++++
 tb/tb_neo_spike_detector.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/neo_pkg.sv
// ----------------------------------------------------------------------------
// neo_pkg
// Definitions shared by the NEO energy stage and its spike detector:
//   - neo_det_state_t : detector FSM states
//   - addr_w(m)       : address width for an m-deep energy buffer
//   - refr_w(r)       : refractory counter width (never less than one bit)
// ----------------------------------------------------------------------------
package neo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } neo_det_state_t;

    // One extra bit over log2 so that a count of m itself is representable.
    function automatic int addr_w(input int m);
        return $clog2(m) + 1;
    endfunction

    // A refractory length of 0 would give a zero-width counter; keep one bit.
    function automatic int refr_w(input int r);
        return (r < 1) ? 1 : $clog2(r + 1);
    endfunction

endpackage

// File: rtl/neo_refractory_ctr.sv
// ----------------------------------------------------------------------------
// neo_refractory_ctr
// Load / decrement counter with a zero flag, used to suppress spike events
// for a fixed number of addresses after each detection.
// Ports:
//   Clk     : clock, rising edge
//   reset   : asynchronous active-low reset (count -> 0)
//   clear   : synchronous clear to 0 (highest priority)
//   freeze  : hold the current count (overrides load/dec)
//   load    : load LOAD_VAL
//   dec     : decrement by one (caller only asserts it when count > 0)
//   zero    : count is zero
// ----------------------------------------------------------------------------
module neo_refractory_ctr #(
    parameter int W        = 2,
    parameter int LOAD_VAL = 3
) (
    input  logic Clk,
    input  logic reset,
    input  logic clear,
    input  logic freeze,
    input  logic load,
    input  logic dec,
    output logic zero
);

    logic [W-1:0] count_r;

    // Counter register: clear > freeze > load > decrement.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            count_r <= {W{1'b0}};
        end else if (clear) begin
            count_r <= {W{1'b0}};
        end else if (freeze) begin
            count_r <= count_r;
        end else if (load) begin
            count_r <= W'(LOAD_VAL);
        end else if (dec && (count_r != {W{1'b0}})) begin
            count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == {W{1'b0}});

endmodule

// File: rtl/neo_spike_detector.sv
// ----------------------------------------------------------------------------
// neo_spike_detector
// Scans the NEO energy buffer (addresses 0..M-1) once per start request and
// emits one event per word strictly above the latched threshold, with a
// refractory window of REFRACT addresses after every detected spike.
// Ports:
//   Clk, reset          : clock (rising edge), async active-low reset
//   start               : scan request, honoured in IDLE only
//   threshold           : signed threshold, latched on accepted start
//   raddr / rdata       : energy buffer read port (combinational read)
//   evt_valid/evt_ready : event handshake to the spike logger
//   evt_addr/evt_energy : address and energy of the spike word
//   busy                : scan in progress (SCAN/HOLD/DONE)
//   done                : one-cycle end-of-scan pulse
//   spike_count         : spikes detected in the last/current scan
// All outputs are registered.
// ----------------------------------------------------------------------------
module neo_spike_detector
    import neo_pkg::*;
#(
    parameter int N       = 8,
    parameter int M       = 16,
    parameter int REFRACT = 3,
    localparam int AW     = addr_w(M)
) (
    input  logic                Clk,
    input  logic                reset,
    input  logic                start,
    input  logic signed [N-1:0] threshold,
    output logic [AW-1:0]       raddr,
    input  logic signed [N-1:0] rdata,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [AW-1:0]       evt_addr,
    output logic signed [N-1:0] evt_energy,
    output logic                busy,
    output logic                done,
    output logic [AW-1:0]       spike_count
);

    localparam int            RW        = refr_w(REFRACT);
    localparam logic [AW-1:0] LAST_ADDR = AW'(M - 1);
    localparam logic [AW-1:0] ONE_A     = AW'(1);

    neo_det_state_t     state_r, state_s;
    logic [AW-1:0]      raddr_r, raddr_s;
    logic               evt_valid_r, evt_valid_s;
    logic [AW-1:0]      evt_addr_r, evt_addr_s;
    logic signed [N-1:0] evt_energy_r, evt_energy_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic [AW-1:0]      spike_count_r, spike_count_s;
    logic signed [N-1:0] thr_r, thr_s;

    logic refr_clear_s, refr_freeze_s, refr_load_s, refr_dec_s, refr_zero_s;
    logic spike_s;

    // Refractory window counter; frozen while an event waits in HOLD.
    neo_refractory_ctr #(
        .W        (RW),
        .LOAD_VAL (REFRACT)
    ) u_refr (
        .Clk    (Clk),
        .reset  (reset),
        .clear  (refr_clear_s),
        .freeze (refr_freeze_s),
        .load   (refr_load_s),
        .dec    (refr_dec_s),
        .zero   (refr_zero_s)
    );

    // Next-state and next-output logic for the scan FSM.
    always_comb begin
        state_s        = state_r;
        raddr_s        = raddr_r;
        evt_valid_s    = evt_valid_r;
        evt_addr_s     = evt_addr_r;
        evt_energy_s   = evt_energy_r;
        done_s         = 1'b0;
        spike_count_s  = spike_count_r;
        thr_s          = thr_r;
        refr_clear_s   = 1'b0;
        refr_freeze_s  = 1'b0;
        refr_load_s    = 1'b0;
        refr_dec_s     = 1'b0;
        // Signed strict compare; above-threshold words inside the window are ignored.
        spike_s        = (rdata > thr_r) && refr_zero_s;

        case (state_r)
            IDLE: begin
                if (start) begin
                    thr_s         = threshold;
                    spike_count_s = {AW{1'b0}};
                    raddr_s       = {AW{1'b0}};
                    refr_clear_s  = 1'b1;
                    state_s       = SCAN;
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                if (spike_s) begin
                    evt_valid_s   = 1'b1;
                    evt_addr_s    = raddr_r;
                    evt_energy_s  = rdata;
                    spike_count_s = spike_count_r + ONE_A;
                    refr_load_s   = 1'b1;
                    state_s       = HOLD;
                    // Hold the last address so raddr never leaves the buffer.
                    raddr_s       = (raddr_r == LAST_ADDR) ? raddr_r : raddr_r + ONE_A;
                end else begin
                    refr_dec_s = !refr_zero_s;
                    if (raddr_r == LAST_ADDR) begin
                        state_s = DONE;
                        done_s  = 1'b1;
                    end else begin
                        raddr_s = raddr_r + ONE_A;
                    end
                end
            end
            HOLD: begin
                refr_freeze_s = 1'b1;
                if (evt_valid_r && evt_ready) begin
                    evt_valid_s = 1'b0;
                    if (evt_addr_r == LAST_ADDR) begin
                        state_s = DONE;
                        done_s  = 1'b1;
                    end else begin
                        state_s = SCAN;
                    end
                end else begin
                    state_s = HOLD;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s     = IDLE;
                evt_valid_s = 1'b0;
            end
        endcase

        busy_s = (state_s != IDLE);
    end

    // State and registered-output update.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_r       <= IDLE;
            raddr_r       <= {AW{1'b0}};
            evt_valid_r   <= 1'b0;
            evt_addr_r    <= {AW{1'b0}};
            evt_energy_r  <= {N{1'b0}};
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            spike_count_r <= {AW{1'b0}};
            thr_r         <= {N{1'b0}};
        end else begin
            state_r       <= state_s;
            raddr_r       <= raddr_s;
            evt_valid_r   <= evt_valid_s;
            evt_addr_r    <= evt_addr_s;
            evt_energy_r  <= evt_energy_s;
            busy_r        <= busy_s;
            done_r        <= done_s;
            spike_count_r <= spike_count_s;
            thr_r         <= thr_s;
        end
    end

    assign raddr       = raddr_r;
    assign evt_valid   = evt_valid_r;
    assign evt_addr    = evt_addr_r;
    assign evt_energy  = evt_energy_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign spike_count = spike_count_r;

endmodule

// File: tb/tb_neo_spike_detector.sv
module tb_neo_spike_detector;

    localparam int N     = 8;
    localparam int M     = 16;
    localparam int RFR   = 3;
    localparam int AW    = 5;
    localparam int LIMIT = 200;

    logic                Clk;
    logic                reset;
    logic                start;
    logic signed [N-1:0] threshold;
    logic [AW-1:0]       raddr;
    logic signed [N-1:0] rdata;
    logic                evt_valid;
    logic                evt_ready;
    logic [AW-1:0]       evt_addr;
    logic signed [N-1:0] evt_energy;
    logic                busy;
    logic                done;
    logic [AW-1:0]       spike_count;

    logic signed [N-1:0] mem [M];

    typedef struct {
        int                  addr;
        logic signed [N-1:0] e;
    } evt_t;
    evt_t exp_q[$];

    int pass_cnt  = 0;
    int total_cnt = 0;

    neo_spike_detector #(.N(N), .M(M), .REFRACT(RFR)) dut (
        .Clk         (Clk),
        .reset       (reset),
        .start       (start),
        .threshold   (threshold),
        .raddr       (raddr),
        .rdata       (rdata),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_addr    (evt_addr),
        .evt_energy  (evt_energy),
        .busy        (busy),
        .done        (done),
        .spike_count (spike_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Combinational energy buffer read.
    assign rdata = (raddr < AW'(M)) ? mem[raddr[3:0]] : 8'sd0;

    task automatic fill(input logic signed [N-1:0] v);
        for (int i = 0; i < M; i++) mem[i] = v;
    endtask

    // Runs one scan, scoreboarding events against a reference walk of mem.
    task automatic do_scan(input string name, input logic signed [N-1:0] thr,
                           input int stall_cycles, input int mid_start_at);
        int refr, nev, exp_done, n, stalls, max_raddr, ra;
        bit finished;
        exp_q.delete();
        refr = 0;
        nev  = 0;
        for (int a = 0; a < M; a++) begin
            if ((mem[a] > thr) && (refr == 0)) begin
                exp_q.push_back('{a, mem[a]});
                refr = RFR;
                nev++;
            end else if (refr > 0) begin
                refr--;
            end
        end
        exp_done  = M + 1 + nev + ((nev > 0) ? stall_cycles : 0);
        stalls    = 0;
        max_raddr = 0;
        finished  = 1'b0;

        threshold = thr;
        start     = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        n     = 1;
        total_cnt++;
        if (busy !== 1'b1 || raddr !== 5'd0) $display("FAIL %s first_cycle busy=%0b raddr=%0d required busy=1 raddr=0", name, busy, raddr);
        else pass_cnt++;

        while (n < LIMIT) begin
            if (done) begin
                finished = 1'b1;
                break;
            end
            if (int'(raddr) > max_raddr) max_raddr = int'(raddr);
            if (evt_valid) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL %s unexpected_event addr=%0d energy=%0d required none", name, evt_addr, evt_energy);
                    evt_ready = 1'b1;
                end else if (stalls < stall_cycles) begin
                    evt_ready = 1'b0;
                    stalls++;
                    ra = (exp_q[0].addr == M - 1) ? M - 1 : exp_q[0].addr + 1;
                    total_cnt++;
                    if (evt_addr !== 5'(exp_q[0].addr) || evt_energy !== exp_q[0].e || raddr !== 5'(ra))
                        $display("FAIL %s stall_hold addr=%0d energy=%0d raddr=%0d required addr=%0d energy=%0d raddr=%0d",
                                 name, evt_addr, evt_energy, raddr, exp_q[0].addr, exp_q[0].e, ra);
                    else pass_cnt++;
                end else begin
                    evt_ready = 1'b1;
                    total_cnt++;
                    if (evt_addr !== 5'(exp_q[0].addr) || evt_energy !== exp_q[0].e)
                        $display("FAIL %s event addr=%0d energy=%0d required addr=%0d energy=%0d",
                                 name, evt_addr, evt_energy, exp_q[0].addr, exp_q[0].e);
                    else pass_cnt++;
                    void'(exp_q.pop_front());
                end
            end else begin
                evt_ready = 1'b1;
            end
            if (n == mid_start_at) begin
                start     = 1'b1;
                threshold = -8'sd128;
            end else begin
                start     = 1'b0;
                threshold = thr;
            end
            @(negedge Clk);
            n++;
        end
        start     = 1'b0;
        evt_ready = 1'b1;

        total_cnt++;
        if (!finished || n != exp_done) $display("FAIL %s done_cycle got=%0d finished=%0b required=%0d", name, n, finished, exp_done);
        else pass_cnt++;
        total_cnt++;
        if (spike_count !== 5'(nev)) $display("FAIL %s spike_count got=%0d required=%0d", name, spike_count, nev);
        else pass_cnt++;
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL %s missing_events got=%0d required=0", name, exp_q.size());
        else pass_cnt++;
        total_cnt++;
        if (max_raddr > M - 1) $display("FAIL %s raddr_max got=%0d required<=%0d", name, max_raddr, M - 1);
        else pass_cnt++;
        @(negedge Clk);
        total_cnt++;
        if (done !== 1'b0 || busy !== 1'b0 || spike_count !== 5'(nev))
            $display("FAIL %s after_done done=%0b busy=%0b count=%0d required done=0 busy=0 count=%0d", name, done, busy, spike_count, nev);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        total_cnt++;
        if ({raddr, evt_valid, evt_addr, evt_energy, busy, done, spike_count} !== 25'd0)
            $display("FAIL reset outputs raddr=%0d v=%0b a=%0d e=%0d busy=%0b done=%0b cnt=%0d required all 0",
                     raddr, evt_valid, evt_addr, evt_energy, busy, done, spike_count);
        else pass_cnt++;
    endtask

    task automatic test_all_below();
        fill(8'sd5);
        do_scan("all_below", 8'sd10, 0, -1);
    endtask

    task automatic test_equality_sign();
        fill(-8'sd10);
        mem[2] = -8'sd4;
        mem[6] = -8'sd3;
        do_scan("eq_sign", -8'sd4, 0, -1);
    endtask

    task automatic test_refractory();
        fill(8'sd0);
        for (int i = 4; i <= 8; i++) mem[i] = 8'sd20;
        do_scan("refractory", 8'sd0, 0, -1);
    endtask

    task automatic test_backpressure();
        fill(8'sd0);
        mem[3] = 8'sd50;
        do_scan("backpressure", 8'sd10, 5, -1);
    endtask

    task automatic test_last_address();
        fill(8'sd1);
        mem[15] = 8'sd40;
        do_scan("last_addr", 8'sd10, 0, 5);
    endtask

    task automatic test_reset_hold();
        int n;
        fill(8'sd0);
        mem[3] = 8'sd50;
        threshold = 8'sd10;
        evt_ready = 1'b0;
        start     = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        n = 0;
        while (!evt_valid && n < 40) begin
            @(negedge Clk);
            n++;
        end
        total_cnt++;
        if (evt_valid !== 1'b1) $display("FAIL reset_hold reach_hold evt_valid=%0b required 1", evt_valid);
        else pass_cnt++;
        reset = 1'b0;
        #1;
        total_cnt++;
        if ({raddr, evt_valid, evt_addr, evt_energy, busy, done, spike_count} !== 25'd0)
            $display("FAIL reset_hold outputs raddr=%0d v=%0b a=%0d e=%0d busy=%0b done=%0b cnt=%0d required all 0",
                     raddr, evt_valid, evt_addr, evt_energy, busy, done, spike_count);
        else pass_cnt++;
        @(negedge Clk);
        total_cnt++;
        if (done !== 1'b0 || evt_valid !== 1'b0) $display("FAIL reset_hold no_done done=%0b v=%0b required 0", done, evt_valid);
        else pass_cnt++;
        reset     = 1'b1;
        evt_ready = 1'b1;
        @(negedge Clk);
        do_scan("after_reset", 8'sd10, 0, -1);
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        threshold = 8'sd0;
        evt_ready = 1'b1;
        fill(8'sd0);
        @(negedge Clk);
        @(negedge Clk);
        test_reset();
        reset = 1'b1;
        @(negedge Clk);
        test_all_below();
        test_equality_sign();
        test_refractory();
        test_backpressure();
        test_last_address();
        test_reset_hold();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
